// File: rtl/mul_rs_dispatch.sv
// Three-entry reservation station feeding the mul/div execution unit: holds renamed
// instructions until both operands are ready, dispatches one at a time, frees on completion.
module mul_rs_dispatch #(
  parameter int DEPTH  = 3,
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_func,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [TAG_W-1:0]  issue_rob,
  input  logic              issue_rs1_rdy,
  input  logic              issue_rs2_rdy,
  input  logic [DATA_W-1:0] issue_rs1_data,
  input  logic [DATA_W-1:0] issue_rs2_data,
  input  logic [TAG_W-1:0]  issue_rs1_tag,
  input  logic [TAG_W-1:0]  issue_rs2_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              ex_busy,
  input  logic              ex_done,
  input  logic [2:0]        ex_done_index,
  input  logic              flush,
  output logic              ex_b,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data,
  output logic [3:0]        ex_func,
  output logic [REG_W-1:0]  ex_rd,
  output logic [TAG_W-1:0]  ex_rob_ind,
  output logic [2:0]        ex_rs_index,
  output logic [1:0]        occupancy,
  output logic              illegal_func
);

  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  typedef struct packed {
    logic              valid;
    logic              disp;
    logic [3:0]        func;
    logic [REG_W-1:0]  rd;
    logic [TAG_W-1:0]  rob;
    logic              rs1_rdy;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0]  rs1_tag;
    logic              rs2_rdy;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0]  rs2_tag;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];
  entry_t sel_ent;

  logic              inflight_q, inflight_d;
  logic              ex_b_q, illegal_q;
  logic [DATA_W-1:0] ex_rs1_q, ex_rs2_q;
  logic [3:0]        ex_func_q;
  logic [REG_W-1:0]  ex_rd_q;
  logic [TAG_W-1:0]  ex_rob_q;
  logic [2:0]        ex_idx_q;

  logic       any_free, any_elig, done_hit, do_alloc, do_disp, issue_fire, func_ok;
  logic [2:0] alloc_idx, sel_idx;
  logic [1:0] occ;

  // Free/eligible decode and lowest-index priority, all from registered state only.
  // NOTE: every combinational output gets a default before any conditional write, so no latches appear.
  always_comb begin
    any_free  = 1'b0;
    any_elig  = 1'b0;
    alloc_idx = '0;
    sel_idx   = '0;
    occ       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        any_free  = 1'b1;
        alloc_idx = 3'(i);
      end
      if (ent_q[i].valid && !ent_q[i].disp && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        any_elig = 1'b1;
        sel_idx  = 3'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) occ = occ + 2'(ent_q[i].valid);
  end

  always_comb begin
    sel_ent  = '0;
    done_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_idx == 3'(i)) sel_ent = ent_q[i];
      if (ex_done && ex_done_index == 3'(i) && ent_q[i].valid && ent_q[i].disp) done_hit = 1'b1;
    end
  end

  assign issue_fire = issue_valid && issue_ready;
  assign func_ok    = (issue_func == FUNC_MUL) || (issue_func == FUNC_DIV);
  assign do_alloc   = issue_fire && func_ok;
  assign do_disp    = any_elig && !inflight_q && !ex_busy;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].valid && cdb_valid) begin
        if (!ent_q[i].rs1_rdy && ent_q[i].rs1_tag == cdb_tag) begin
          ent_d[i].rs1_rdy  = 1'b1;
          ent_d[i].rs1_data = cdb_data;
        end
        if (!ent_q[i].rs2_rdy && ent_q[i].rs2_tag == cdb_tag) begin
          ent_d[i].rs2_rdy  = 1'b1;
          ent_d[i].rs2_data = cdb_data;
        end
      end
      if (do_disp && sel_idx == 3'(i)) ent_d[i].disp = 1'b1;
      if (done_hit && ex_done_index == 3'(i)) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].disp  = 1'b0;
      end
      // New entry can bypass a same-cycle broadcast of its missing operand.
      if (do_alloc && alloc_idx == 3'(i)) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].disp     = 1'b0;
        ent_d[i].func     = issue_func;
        ent_d[i].rd       = issue_rd;
        ent_d[i].rob      = issue_rob;
        ent_d[i].rs1_tag  = issue_rs1_tag;
        ent_d[i].rs2_tag  = issue_rs2_tag;
        ent_d[i].rs1_rdy  = issue_rs1_rdy || (cdb_valid && issue_rs1_tag == cdb_tag);
        ent_d[i].rs1_data = issue_rs1_rdy ? issue_rs1_data : cdb_data;
        ent_d[i].rs2_rdy  = issue_rs2_rdy || (cdb_valid && issue_rs2_tag == cdb_tag);
        ent_d[i].rs2_data = issue_rs2_rdy ? issue_rs2_data : cdb_data;
      end
      if (flush) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].disp  = 1'b0;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (flush)         inflight_d = 1'b0;
    else if (do_disp)  inflight_d = 1'b1;
    else if (done_hit) inflight_d = 1'b0;
  end

  // NOTE: the whole entry array is reset, payload included, so dispatched outputs never carry X after reset.
  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      inflight_q <= 1'b0;
      ex_b_q     <= 1'b0;
      illegal_q  <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_func_q  <= '0;
      ex_rd_q    <= '0;
      ex_rob_q   <= '0;
      ex_idx_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      inflight_q <= inflight_d;
      ex_b_q     <= do_disp && !flush;
      illegal_q  <= issue_fire && !func_ok && !flush;
      if (do_disp && !flush) begin
        ex_rs1_q  <= sel_ent.rs1_data;
        ex_rs2_q  <= sel_ent.rs2_data;
        ex_func_q <= sel_ent.func;
        ex_rd_q   <= sel_ent.rd;
        ex_rob_q  <= sel_ent.rob;
        ex_idx_q  <= sel_idx;
      end
    end
  end

  assign issue_ready  = any_free;
  assign occupancy    = occ;
  assign illegal_func = illegal_q;
  assign ex_b         = ex_b_q;
  assign ex_rs1_data  = ex_rs1_q;
  assign ex_rs2_data  = ex_rs2_q;
  assign ex_func      = ex_func_q;
  assign ex_rd        = ex_rd_q;
  assign ex_rob_ind   = ex_rob_q;
  assign ex_rs_index  = ex_idx_q;

endmodule

// File: tb/tb_mul_rs_dispatch.sv
// Directed bench for mul_rs_dispatch: issue, bypass, CDB snoop, full station,
// illegal func, flush and asynchronous reset, with hand-computed expectations.
module tb_mul_rs_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       issue_valid, issue_ready;
  logic [3:0] issue_func;
  logic [3:0] issue_rd;
  logic [2:0] issue_rob;
  logic       issue_rs1_rdy, issue_rs2_rdy;
  logic [7:0] issue_rs1_data, issue_rs2_data;
  logic [2:0] issue_rs1_tag, issue_rs2_tag;
  logic       cdb_valid;
  logic [2:0] cdb_tag;
  logic [7:0] cdb_data;
  logic       ex_busy, ex_done;
  logic [2:0] ex_done_index;
  logic       flush;
  logic       ex_b;
  logic [7:0] ex_rs1_data, ex_rs2_data;
  logic [3:0] ex_func;
  logic [3:0] ex_rd;
  logic [2:0] ex_rob_ind, ex_rs_index;
  logic [1:0] occupancy;
  logic       illegal_func;

  int n_checks = 0;
  int n_pass   = 0;

  mul_rs_dispatch dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_func(issue_func),
    .issue_rd(issue_rd), .issue_rob(issue_rob),
    .issue_rs1_rdy(issue_rs1_rdy), .issue_rs2_rdy(issue_rs2_rdy),
    .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
    .issue_rs1_tag(issue_rs1_tag), .issue_rs2_tag(issue_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_busy(ex_busy), .ex_done(ex_done), .ex_done_index(ex_done_index), .flush(flush),
    .ex_b(ex_b), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_func(ex_func), .ex_rd(ex_rd), .ex_rob_ind(ex_rob_ind), .ex_rs_index(ex_rs_index),
    .occupancy(occupancy), .illegal_func(illegal_func)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [3:0] func, input logic [3:0] rd, input logic [2:0] rob,
                             input logic r1_rdy, input logic [7:0] r1_data, input logic [2:0] r1_tag,
                             input logic r2_rdy, input logic [7:0] r2_data, input logic [2:0] r2_tag);
    issue_valid    = 1'b1;
    issue_func     = func;
    issue_rd       = rd;
    issue_rob      = rob;
    issue_rs1_rdy  = r1_rdy;
    issue_rs1_data = r1_data;
    issue_rs1_tag  = r1_tag;
    issue_rs2_rdy  = r2_rdy;
    issue_rs2_data = r2_data;
    issue_rs2_tag  = r2_tag;
  endtask

  task automatic complete(input logic [2:0] idx);
    ex_done       = 1'b1;
    ex_done_index = idx;
    tick();
    ex_done       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    issue_valid = 1'b0; issue_func = '0; issue_rd = '0; issue_rob = '0;
    issue_rs1_rdy = 1'b0; issue_rs2_rdy = 1'b0; issue_rs1_data = '0; issue_rs2_data = '0;
    issue_rs1_tag = '0; issue_rs2_tag = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    ex_busy = 1'b0; ex_done = 1'b0; ex_done_index = '0; flush = 1'b0;

    #12;
    check("rst issue_ready", 32'(issue_ready), 1);
    check("rst occupancy", 32'(occupancy), 0);
    check("rst ex_b", 32'(ex_b), 0);
    check("rst illegal", 32'(illegal_func), 0);
    check("rst ex_rs1", 32'(ex_rs1_data), 0);
    rst_n = 1'b1;
    tick();

    // Both operands ready: dispatch one edge after issue.
    drive_issue(4'b0010, 4'd4, 3'd2, 1'b1, 8'h05, 3'd0, 1'b1, 8'h03, 3'd0);
    tick();
    issue_valid = 1'b0;
    check("t1 occ after issue", 32'(occupancy), 1);
    check("t1 no early ex_b", 32'(ex_b), 0);
    tick();
    check("t1 ex_b", 32'(ex_b), 1);
    check("t1 rs1", 32'(ex_rs1_data), 32'h05);
    check("t1 rs2", 32'(ex_rs2_data), 32'h03);
    check("t1 func", 32'(ex_func), 32'h2);
    check("t1 rd", 32'(ex_rd), 4);
    check("t1 rob", 32'(ex_rob_ind), 2);
    check("t1 index", 32'(ex_rs_index), 0);
    check("t1 occ", 32'(occupancy), 1);
    tick();
    check("t1 ex_b one cycle", 32'(ex_b), 0);
    complete(3'd0);
    check("t1 occ freed", 32'(occupancy), 0);

    // Divide waiting on tag 5, broadcast two cycles after issue.
    drive_issue(4'b0011, 4'd7, 3'd3, 1'b1, 8'h10, 3'd0, 1'b0, 8'h00, 3'd5);
    tick();
    issue_valid = 1'b0;
    tick();
    check("t2 waiting", 32'(ex_b), 0);
    cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 8'h02;
    tick();
    cdb_valid = 1'b0;
    check("t2 not at capture", 32'(ex_b), 0);
    tick();
    check("t2 ex_b", 32'(ex_b), 1);
    check("t2 rs2 from cdb", 32'(ex_rs2_data), 32'h02);
    check("t2 rs1", 32'(ex_rs1_data), 32'h10);
    check("t2 func", 32'(ex_func), 32'h3);
    check("t2 rob", 32'(ex_rob_ind), 3);
    complete(3'd0);

    // Issue-time bypass of a same-cycle broadcast.
    drive_issue(4'b0010, 4'd1, 3'd4, 1'b0, 8'h00, 3'd3, 1'b1, 8'h07, 3'd0);
    cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 8'h09;
    tick();
    issue_valid = 1'b0; cdb_valid = 1'b0;
    tick();
    check("t3 ex_b", 32'(ex_b), 1);
    check("t3 rs1 bypass", 32'(ex_rs1_data), 32'h09);
    check("t3 rs2", 32'(ex_rs2_data), 32'h07);
    complete(3'd0);

    // Fill all three entries.
    drive_issue(4'b0010, 4'd1, 3'd0, 1'b1, 8'h01, 3'd0, 1'b1, 8'h02, 3'd0);
    tick();
    drive_issue(4'b0010, 4'd2, 3'd1, 1'b1, 8'h03, 3'd0, 1'b1, 8'h04, 3'd0);
    tick();
    check("t4 ex_b idx0", 32'(ex_b), 1);
    check("t4 index 0", 32'(ex_rs_index), 0);
    check("t4 rs1 e0", 32'(ex_rs1_data), 32'h01);
    drive_issue(4'b0011, 4'd3, 3'd2, 1'b1, 8'h05, 3'd0, 1'b1, 8'h06, 3'd0);
    tick();
    check("t4 single dispatch", 32'(ex_b), 0);
    check("t4 occ full", 32'(occupancy), 3);
    check("t4 issue_ready full", 32'(issue_ready), 0);
    // Legal issue held while full; ex_done to a non-dispatched entry is ignored.
    drive_issue(4'b0010, 4'd9, 3'd7, 1'b1, 8'hAA, 3'd0, 1'b1, 8'hBB, 3'd0);
    complete(3'd1);
    check("t4 bogus done occ", 32'(occupancy), 3);
    check("t4 bogus done no ex_b", 32'(ex_b), 0);
    complete(3'd0);
    issue_valid = 1'b0;
    check("t4 no alloc on done", 32'(occupancy), 2);
    check("t4 issue_ready freed", 32'(issue_ready), 1);
    check("t4 no ex_b at done", 32'(ex_b), 0);
    tick();
    check("t4 ex_b idx1", 32'(ex_b), 1);
    check("t4 index 1", 32'(ex_rs_index), 1);
    check("t4 rs1 e1", 32'(ex_rs1_data), 32'h03);
    check("t4 rob e1", 32'(ex_rob_ind), 1);
    complete(3'd1);
    check("t4 occ 1", 32'(occupancy), 1);
    tick();
    check("t4 index 2", 32'(ex_rs_index), 2);
    check("t4 rs2 e2", 32'(ex_rs2_data), 32'h06);
    complete(3'd2);
    check("t4 empty", 32'(occupancy), 0);

    // Unsupported function: dropped, one-cycle pulse.
    drive_issue(4'b0100, 4'd5, 3'd5, 1'b1, 8'h11, 3'd0, 1'b1, 8'h22, 3'd0);
    tick();
    issue_valid = 1'b0;
    check("t5 illegal pulse", 32'(illegal_func), 1);
    check("t5 occ unchanged", 32'(occupancy), 0);
    tick();
    check("t5 illegal clears", 32'(illegal_func), 0);
    check("t5 no dispatch", 32'(ex_b), 0);

    // Flush with one entry in flight and one waiting.
    drive_issue(4'b0010, 4'd2, 3'd1, 1'b1, 8'h11, 3'd0, 1'b1, 8'h22, 3'd0);
    tick();
    drive_issue(4'b0010, 4'd3, 3'd2, 1'b1, 8'h33, 3'd0, 1'b0, 8'h00, 3'd6);
    tick();
    issue_valid = 1'b0;
    check("t6 inflight ex_b", 32'(ex_b), 1);
    check("t6 occ 2", 32'(occupancy), 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t6 flush occ", 32'(occupancy), 0);
    check("t6 flush ex_b", 32'(ex_b), 0);
    check("t6 flush ready", 32'(issue_ready), 1);
    complete(3'd0);
    check("t6 late done occ", 32'(occupancy), 0);
    check("t6 late done ex_b", 32'(ex_b), 0);
    drive_issue(4'b0010, 4'd6, 3'd3, 1'b1, 8'h21, 3'd0, 1'b1, 8'h02, 3'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    check("t6 post-flush dispatch", 32'(ex_b), 1);
    check("t6 post-flush rs1", 32'(ex_rs1_data), 32'h21);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst occ", 32'(occupancy), 0);
    check("arst ex_b", 32'(ex_b), 0);
    check("arst ex_rs1", 32'(ex_rs1_data), 0);
    check("arst ready", 32'(issue_ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
